// File: rtl/mp_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// state encoding, word width and the signed-overflow helper.
package mp_add_sequencer_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two's-complement overflow: operands share a sign and the sum's sign differs.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mp_add_sequencer_if.sv
// Command/result bus of the sequencer. A command transfers on a rising clk edge
// with start_valid & start_ready; a result transfers on an edge with res_valid & res_ready.
interface mp_add_sequencer_if #(
  parameter int WORDS = 4
);
  import mp_add_sequencer_pkg::*;

  localparam int DW = WORDS * WIDTH;

  logic          start_valid;
  logic          start_ready;
  logic          sub;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] result;
  logic          cout;
  logic          overflow;
  logic          busy;

  modport master (
    output start_valid, sub, op_a, op_b, res_ready,
    input  start_ready, res_valid, result, cout, overflow, busy
  );

  modport slave (
    input  start_valid, sub, op_a, op_b, res_ready,
    output start_ready, res_valid, result, cout, overflow, busy
  );

endinterface

// File: rtl/mp_word_add.sv
// Combinational 16-bit carry-lookahead adder: four 4-bit lookahead groups
// joined by a second lookahead level across the group generate/propagate terms.
module mp_word_add
  import mp_add_sequencer_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [3:0]       gg;
  logic [3:0]       gp;
  logic [4:0]       gc;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B = 4 * k;

    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B +: 4];

    assign c[B]   = gc[k];
    assign c[B+1] = g[B] | (p[B] & gc[k]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[k]);
  end

  // Group carries are fully expanded so no carry ripples between groups.
  assign gc[0] = cin_i;
  assign gc[1] = gg[0] | (gp[0] & cin_i);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_i);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin_i);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin_i);

  assign sum_o  = p ^ c;
  assign cout_o = gc[4];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract controller: one word adder is stepped across
// WORDS words, least significant first, with the carry held in a register.
module mp_add_sequencer
  import mp_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  mp_add_sequencer_if.slave         bus_if,
  output state_e                    state_o
);

  localparam int DW   = WORDS * WIDTH;
  localparam int IDXW = $clog2(WORDS);

  state_e           state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [DW-1:0]    a_q;
  logic [DW-1:0]    b_q;
  logic [DW-1:0]    result_q;
  logic [DW-1:0]    result_d;
  logic             cout_q;
  logic             ovf_q;

  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [WIDTH-1:0] sum_word;
  logic             word_cout;
  logic             last_word;

  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        a_word = a_q[w*WIDTH +: WIDTH];
        b_word = b_q[w*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    result_d = result_q;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDXW'(w)) result_d[w*WIDTH +: WIDTH] = sum_word;
    end
  end

  assign last_word = (idx_q == IDXW'(WORDS - 1));

  mp_word_add u_word_add (
    .a_i    (a_word),
    .b_i    (b_word),
    .cin_i  (carry_q),
    .sum_o  (sum_word),
    .cout_o (word_cout)
  );

  // b_q holds the effective operand: subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_if.start_valid) begin
            a_q      <= bus_if.op_a;
            b_q      <= bus_if.sub ? ~bus_if.op_b : bus_if.op_b;
            carry_q  <= bus_if.sub;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= word_cout;
          idx_q    <= idx_q + IDXW'(1);
          if (last_word) begin
            idx_q   <= '0;
            cout_q  <= word_cout;
            ovf_q   <= signed_ovf(a_word[WIDTH-1], b_word[WIDTH-1], sum_word[WIDTH-1]);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus_if.res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.start_ready = (state_q == IDLE);
  assign bus_if.res_valid   = (state_q == DONE);
  assign bus_if.busy        = (state_q != IDLE);
  assign bus_if.result      = result_q;
  assign bus_if.cout        = cout_q;
  assign bus_if.overflow    = ovf_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer at WORDS=4: a vector table of add/sub
// cases plus hand-written backpressure, back-to-back and mid-operation reset sequences.
module tb_mp_add_sequencer;
  import mp_add_sequencer_pkg::*;

  localparam int WORDS = 4;
  localparam int DW    = WORDS * WIDTH;
  localparam int NV    = 8;

  typedef struct {
    logic          sub;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          cout;
    logic          ovf;
  } vec_t;

  logic   clk;
  logic   rst;
  state_e state_dbg;
  int     tests_run;
  int     tests_failed;
  vec_t   vecs[NV];
  logic [DW-1:0] exp_q[$];

  mp_add_sequencer_if #(.WORDS(WORDS)) bus ();

  mp_add_sequencer #(.WORDS(WORDS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus_if  (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_res, input logic exp_cout, input logic exp_ovf,
                        input int hold, input string tag);
    int cyc;
    @(negedge clk);
    check({tag, ".start_ready"}, bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.sub         = s;
    bus.op_a        = a;
    bus.op_b        = b;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.op_a        = ~a;
    bus.op_b        = ~b;
    bus.sub         = ~s;
    bus.res_ready   = 1'b1;
    cyc = 0;
    while (!bus.res_valid && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.res_ready = 1'b0;
    end
    bus.res_ready = 1'b0;
    check({tag, ".latency"}, DW'(cyc), DW'(WORDS));
    for (int h = 0; h < hold; h++) begin
      check($sformatf("%s.hold%0d.res_valid", tag, h), bus.res_valid, 1);
      check($sformatf("%s.hold%0d.result", tag, h), bus.result, exp_res);
      check($sformatf("%s.hold%0d.cout", tag, h), bus.cout, exp_cout);
      check($sformatf("%s.hold%0d.start_ready", tag, h), bus.start_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, ".result"}, bus.result, exp_res);
    check({tag, ".cout"}, bus.cout, exp_cout);
    check({tag, ".overflow"}, bus.overflow, exp_ovf);
    check({tag, ".busy"}, bus.busy, 1);
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, ".post.start_ready"}, bus.start_ready, 1);
    check({tag, ".post.res_valid"}, bus.res_valid, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int accepts;
    int nres;
    int done_cyc;
    logic [DW-1:0] exp_r;

    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.sub         = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.res_ready   = 1'b0;

    vecs[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 64'h5, 64'h3, 64'h2, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 64'h3, 64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.start_ready", bus.start_ready, 1);
    check("reset.res_valid", bus.res_valid, 0);
    check("reset.busy", bus.busy, 0);
    check("reset.result", bus.result, 0);
    check("reset.cout", bus.cout, 0);
    check("reset.overflow", bus.overflow, 0);
    check("reset.state", state_dbg, IDLE);

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cout, vecs[i].ovf,
             0, $sformatf("vec%0d", i));

    // Backpressure: result held for three cycles before the consumer takes it.
    run_op(1'b0, 64'h0000_0000_0001_FFFF, 64'h0000_0000_0000_0001,
           64'h0000_0000_0002_0000, 1'b0, 1'b0, 3, "backpressure");

    // Back-to-back with start_valid and res_ready held high throughout.
    exp_q.push_back(64'h1235);
    exp_q.push_back(64'h1_0000);
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.sub         = 1'b0;
    bus.op_a        = 64'h1234;
    bus.op_b        = 64'h1;
    bus.res_ready   = 1'b1;
    accepts  = 0;
    nres     = 0;
    done_cyc = -10;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (accepts == 1) begin
        bus.op_a = 64'hFFFF;
        bus.op_b = 64'h1;
      end else if (accepts == 2) begin
        bus.start_valid = 1'b0;
      end
      if (bus.res_valid) begin
        exp_r = exp_q.pop_front();
        check($sformatf("b2b.result%0d", nres), bus.result, exp_r);
        check($sformatf("b2b.no_accept%0d", nres), bus.start_ready, 0);
        done_cyc = c;
        nres++;
      end
      if (bus.start_ready && bus.start_valid) begin
        accepts++;
        if (accepts == 2) check("b2b.second_accept_cycle", DW'(c), DW'(done_cyc + 1));
      end
      @(posedge clk);
    end
    check("b2b.results_seen", DW'(nres), DW'(2));
    @(negedge clk);
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;

    // Reset two cycles into RUN aborts the operation.
    @(negedge clk);
    bus.start_valid = 1'b1;
    bus.sub         = 1'b0;
    bus.op_a        = 64'h1111_2222_3333_4444;
    bus.op_b        = 64'h5555_6666_7777_8888;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst.busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst.res_valid", bus.res_valid, 0);
    check("midrst.busy", bus.busy, 0);
    check("midrst.result", bus.result, 0);
    check("midrst.start_ready", bus.start_ready, 1);
    run_op(1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
           64'h6666_8888_AAAA_CCCC, 1'b0, 1'b0, 0, "after_rst");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
